// File: rtl/pixel_plot_sink.sv
// Pixel plot sink: queues (x, y, colour) requests, maps them to framebuffer addresses, issues writes.
// Optional clear-screen engine enabled by defining PIXEL_SINK_CLEAR_EN.
module pixel_plot_sink #(
   parameter int H_RES      = 160,
   parameter int V_RES      = 120,
   parameter int COLOR_W    = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         in_x,
   input  logic [6:0]         in_y,
   input  logic [COLOR_W-1:0] in_colour,
   input  logic               in_plot,
   output logic               in_ready,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_data,
   output logic               mem_we,
   input  logic               mem_ready,
   output logic [7:0]         drop_cnt,
   output logic               busy,
   input  logic               clear_req,
   input  logic [COLOR_W-1:0] clear_colour,
   output logic               clear_done,
   output logic [1:0]         dbg_state
);

`ifdef PIXEL_SINK_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int TOTAL = H_RES * V_RES;
   localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(TOTAL);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_CLEAR = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e state_q, state_d;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1
   // (in_plot/in_ready upstream, mem_we/mem_ready downstream); valid payload holds until then.
   logic [7:0]         fx_q [FIFO_DEPTH];
   logic [6:0]         fy_q [FIFO_DEPTH];
   logic [COLOR_W-1:0] fc_q [FIFO_DEPTH];
   logic [AW:0]        wr_ptr_q, rd_ptr_q, fifo_cnt;
   logic               fifo_empty, fifo_full, push, pop;

   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [COLOR_W-1:0] data_q, data_d;
   logic               we_q, we_d;
   logic [7:0]         drop_q, drop_d;
   logic [ADDR_W:0]    clr_q, clr_d;
   logic [COLOR_W-1:0] clr_col_q, clr_col_d;

   logic [7:0]         head_x;
   logic [6:0]         head_y;
   logic [COLOR_W-1:0] head_c;
   logic               head_ok, out_free;
   logic [ADDR_W-1:0]  head_addr;

   assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
   assign in_ready   = !fifo_full && (state_q == S_IDLE);
   assign push       = in_plot && in_ready;

   assign head_x    = fx_q[rd_ptr_q[AW-1:0]];
   assign head_y    = fy_q[rd_ptr_q[AW-1:0]];
   assign head_c    = fc_q[rd_ptr_q[AW-1:0]];
   assign head_ok   = ({1'b0, head_x} < 9'(H_RES)) && ({1'b0, head_y} < 8'(V_RES));
   assign head_addr = ADDR_W'(head_y) * ADDR_W'(H_RES) + ADDR_W'(head_x);

   // The output register may be reloaded when empty or when its write is accepted this cycle.
   assign out_free = !we_q || mem_ready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      we_d      = we_q;
      drop_d    = drop_q;
      clr_d     = clr_q;
      clr_col_d = clr_col_q;
      pop       = 1'b0;
      if (state_q == S_CLEAR) begin
         if (out_free) begin
            if (clr_q < CLR_END) begin
               addr_d = clr_q[ADDR_W-1:0];
               data_d = clr_col_q;
               we_d   = 1'b1;
               clr_d  = clr_q + 1'b1;
            end else begin
               we_d    = 1'b0;
               state_d = S_DONE;
            end
         end
      end else begin
         if (out_free) begin
            we_d = 1'b0;
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head_ok) begin
                  addr_d = head_addr;
                  data_d = head_c;
                  we_d   = 1'b1;
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
         end
         case (state_q)
            S_IDLE:  if (CLEAR_EN && clear_req) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty && !we_q) begin
               clr_col_d = clear_colour;
               clr_d     = '0;
               state_d   = S_CLEAR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         drop_q    <= '0;
         clr_q     <= '0;
         clr_col_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         we_q      <= we_d;
         drop_q    <= drop_d;
         clr_q     <= clr_d;
         clr_col_q <= clr_col_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Payload storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fx_q[wr_ptr_q[AW-1:0]] <= in_x;
         fy_q[wr_ptr_q[AW-1:0]] <= in_y;
         fc_q[wr_ptr_q[AW-1:0]] <= in_colour;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign mem_we     = we_q;
   assign drop_cnt   = drop_q;
   assign busy       = !fifo_empty || we_q || (state_q != S_IDLE);
   assign clear_done = (state_q == S_DONE);
   assign dbg_state  = state_q;

endmodule
